// File: rtl/framebuffer_writer.sv
// rtl/framebuffer_writer.sv - pixel writer for a 160x120 framebuffer with FIFO, clipping and full-screen clear
module framebuffer_writer (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic [2:0]  colour,
    input  logic        writeEn,
    output logic        ready,
    input  logic        clear,
    input  logic [2:0]  clear_colour,
    output logic        busy,
    output logic [14:0] mem_addr,
    output logic [2:0]  mem_data,
    output logic        mem_we,
    input  logic        mem_stall,
    output logic [7:0]  dropped,
    output logic        overflow
);

    localparam logic [14:0] LAST_ADDR = 15'd19199;

    typedef enum logic {S_RUN, S_CLEAR} state_t;

    state_t      state_q, state_d;
    logic [17:0] fifo_mem_q [8];
    logic [2:0]  wr_ptr_q, wr_ptr_d;
    logic [2:0]  rd_ptr_q, rd_ptr_d;
    logic [3:0]  count_q, count_d;
    logic [14:0] mem_addr_q, mem_addr_d;
    logic [2:0]  mem_data_q, mem_data_d;
    logic        mem_we_q, mem_we_d;
    logic [14:0] clr_addr_q, clr_addr_d;
    logic [2:0]  clr_colour_q, clr_colour_d;
    logic        clear_pend_q, clear_pend_d;
    logic [7:0]  dropped_q, dropped_d;
    logic        overflow_q, overflow_d;

    logic        out_free;
    logic        in_range;
    logic [14:0] pix_addr;
    logic        start_clear;
    logic        clear_done;
    logic        accept;
    logic        push;
    logic        pop;

    // Only the in-range bits matter once clipping has passed: y*160 + x = (y<<7) + (y<<5) + x
    assign in_range    = (x < 10'd160) && (y < 10'd120);
    assign pix_addr    = {1'b0, y[6:0], 7'b0} + {3'b0, y[6:0], 5'b0} + {7'b0, x[7:0]};
    assign out_free    = !mem_we_q || !mem_stall;
    assign start_clear = (state_q == S_RUN) && (clear || clear_pend_q) && out_free;
    assign clear_done  = (state_q == S_CLEAR) && out_free && mem_we_q && (mem_addr_q == LAST_ADDR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN:   if (start_clear) state_d = S_CLEAR;
            S_CLEAR: if (clear_done)  state_d = S_RUN;
            default: state_d = S_RUN;
        endcase
    end

    always_comb begin
        ready = (state_q == S_RUN) && !count_q[3];
        busy  = (state_q == S_CLEAR);
    end

    always_comb begin
        accept = writeEn && ready;
        // A pixel accepted on the clear transition edge is flushed with the rest of the FIFO
        push   = accept && in_range && !start_clear;
        pop    = (state_q == S_RUN) && !start_clear && out_free && (count_q != 4'd0);

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 3'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 3'd1;
        end
        if (push && !pop) begin
            count_d = count_q + 4'd1;
        end else if (pop && !push) begin
            count_d = count_q - 4'd1;
        end
        if (start_clear) begin
            wr_ptr_d = 3'd0;
            rd_ptr_d = 3'd0;
            count_d  = 4'd0;
        end

        clear_pend_d = clear_pend_q;
        if (start_clear) begin
            clear_pend_d = 1'b0;
        end else if ((state_q == S_RUN) && clear) begin
            clear_pend_d = 1'b1;
        end

        dropped_d = dropped_q;
        if (accept && !in_range && (dropped_q != 8'hFF)) begin
            dropped_d = dropped_q + 8'd1;
        end
        overflow_d = overflow_q || (writeEn && !ready);

        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        mem_we_d     = mem_we_q;
        clr_addr_d   = clr_addr_q;
        clr_colour_d = clr_colour_q;
        if (out_free) begin
            if (start_clear) begin
                mem_addr_d   = 15'd0;
                mem_data_d   = clear_colour;
                mem_we_d     = 1'b1;
                clr_addr_d   = 15'd1;
                clr_colour_d = clear_colour;
            end else if (state_q == S_CLEAR) begin
                if (clear_done) begin
                    mem_we_d = 1'b0;
                end else begin
                    mem_addr_d = clr_addr_q;
                    mem_data_d = clr_colour_q;
                    mem_we_d   = 1'b1;
                    clr_addr_d = clr_addr_q + 15'd1;
                end
            end else if (pop) begin
                {mem_addr_d, mem_data_d} = fifo_mem_q[rd_ptr_q];
                mem_we_d = 1'b1;
            end else begin
                mem_we_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= {pix_addr, colour};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= 3'd0;
            rd_ptr_q     <= 3'd0;
            count_q      <= 4'd0;
            mem_addr_q   <= 15'd0;
            mem_data_q   <= 3'd0;
            mem_we_q     <= 1'b0;
            clr_addr_q   <= 15'd0;
            clr_colour_q <= 3'd0;
            clear_pend_q <= 1'b0;
            dropped_q    <= 8'd0;
            overflow_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            mem_we_q     <= mem_we_d;
            clr_addr_q   <= clr_addr_d;
            clr_colour_q <= clr_colour_d;
            clear_pend_q <= clear_pend_d;
            dropped_q    <= dropped_d;
            overflow_q   <= overflow_d;
        end
    end

    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;
    assign mem_we   = mem_we_q;
    assign dropped  = dropped_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_framebuffer_writer.sv
// tb/tb_framebuffer_writer.sv - directed self-checking bench for framebuffer_writer
module tb_framebuffer_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [2:0]  colour;
    logic        writeEn;
    logic        ready;
    logic        clear;
    logic [2:0]  clear_colour;
    logic        busy;
    logic [14:0] mem_addr;
    logic [2:0]  mem_data;
    logic        mem_we;
    logic        mem_stall;
    logic [7:0]  dropped;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;

    framebuffer_writer dut (
        .clk          (clk),
        .reset        (reset),
        .x            (x),
        .y            (y),
        .colour       (colour),
        .writeEn      (writeEn),
        .ready        (ready),
        .clear        (clear),
        .clear_colour (clear_colour),
        .busy         (busy),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .mem_we       (mem_we),
        .mem_stall    (mem_stall),
        .dropped      (dropped),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset;
        reset = 1'b1;
        #1;
        tick;
        reset = 1'b0;
        #1;
    endtask

    initial begin
        int we_seen;
        int cycles;
        int nxt;
        int err;
        int guard;

        reset = 1'b1; x = '0; y = '0; colour = '0; writeEn = 1'b0;
        clear = 1'b0; clear_colour = '0; mem_stall = 1'b0;
        tick;
        check("rst_we", mem_we, 0);
        check("rst_busy", busy, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_data", mem_data, 0);
        reset = 1'b0;
        #1;
        check("rst_ready", ready, 1);
        check("rst_dropped", dropped, 0);
        check("rst_overflow", overflow, 0);

        // Single pixel: two edges from offer to write
        x = 10'd5; y = 10'd2; colour = 3'b100; writeEn = 1'b1;
        tick;
        writeEn = 1'b0;
        check("sp_lat1", mem_we, 0);
        tick;
        check("sp_write", {mem_we, mem_data, mem_addr}, {1'b1, 3'b100, 15'd325});
        tick;
        check("sp_done", mem_we, 0);

        // Last on-screen pixel
        x = 10'd159; y = 10'd119; colour = 3'b111; writeEn = 1'b1;
        tick;
        writeEn = 1'b0;
        tick;
        check("corner_write", {mem_we, mem_data, mem_addr}, {1'b1, 3'b111, 15'd19199});
        tick;

        // Clipping and saturation
        we_seen = 0;
        x = 10'd160; y = 10'd0; writeEn = 1'b1;
        tick;
        if (mem_we) we_seen++;
        x = 10'd0; y = 10'd120;
        tick;
        if (mem_we) we_seen++;
        check("clip_two", dropped, 2);
        for (int i = 0; i < 300; i++) begin
            x = 10'd200 + 10'(i % 50); y = 10'd500;
            tick;
            if (mem_we) we_seen++;
        end
        writeEn = 1'b0;
        tick;
        if (mem_we) we_seen++;
        check("clip_no_we", we_seen, 0);
        check("clip_sat", dropped, 255);
        check("clip_ovf", overflow, 0);

        // Backpressure: 9 accepted, 10th overflows
        mem_stall = 1'b1;
        for (int i = 0; i < 9; i++) begin
            x = 10'(i); y = 10'd1; colour = 3'(i); writeEn = 1'b1;
            tick;
        end
        check("bp_ready", ready, 0);
        check("bp_head", {mem_we, mem_addr}, {1'b1, 15'd160});
        x = 10'd9; colour = 3'd1;
        tick;
        writeEn = 1'b0;
        check("bp_ovf", overflow, 1);
        check("bp_dropped", dropped, 255);
        tick; tick;
        check("bp_hold", {mem_we, mem_data, mem_addr}, {1'b1, 3'd0, 15'd160});
        mem_stall = 1'b0;
        #1;
        for (int i = 0; i < 9; i++) begin
            check($sformatf("bp_wr%0d", i), {mem_we, mem_data, mem_addr},
                  {1'b1, 3'(i), 15'(160 + i)});
            tick;
        end
        check("bp_drain", mem_we, 0);

        do_reset;
        check("rst2_ovf", overflow, 0);
        check("rst2_dropped", dropped, 0);

        // Full-screen clear
        clear = 1'b1; clear_colour = 3'b001;
        tick;
        clear = 1'b0;
        check("clr_busy", busy, 1);
        check("clr_ready", ready, 0);
        cycles = 0; nxt = 0; err = 0;
        while (busy && cycles < 20000) begin
            if (mem_we && mem_addr == 15'(nxt) && mem_data == 3'b001) nxt++;
            else err++;
            writeEn = (cycles == 100);
            x = 10'd1; y = 10'd1;
            cycles++;
            tick;
        end
        writeEn = 1'b0;
        check("clr_cycles", cycles, 19200);
        check("clr_addrs", nxt, 19200);
        check("clr_errs", err, 0);
        check("clr_end_busy", busy, 0);
        check("clr_end_we", mem_we, 0);
        check("clr_ovf", overflow, 1);
        check("clr_end_ready", ready, 1);

        // Reset in the middle of a clear
        clear = 1'b1; clear_colour = 3'b010;
        tick;
        clear = 1'b0;
        guard = 0;
        while (mem_addr != 15'd5000 && guard < 6000) begin
            guard++;
            tick;
        end
        check("mid_reached", mem_addr, 5000);
        reset = 1'b1;
        #1;
        check("mid_rst_we", mem_we, 0);
        check("mid_rst_busy", busy, 0);
        tick;
        reset = 1'b0;
        #1;
        check("mid_ready", ready, 1);
        we_seen = 0;
        for (int i = 0; i < 50; i++) begin
            tick;
            if (mem_we || busy) we_seen++;
        end
        check("mid_no_resume", we_seen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
